// File: rtl/key_bounce_gen.sv
// Emulated mechanical key: active-low line with bounce glitches around a held press.
// Define KEY_BOUNCE_LFSR_EN for pseudo-random glitch widths; otherwise every glitch is GLITCH_MAX.
module key_bounce_gen #(
  parameter int unsigned BOUNCE_CNT = 6,
  parameter int unsigned GLITCH_MAX = 255,
  parameter logic [29:0] HOLD_CYC   = 30'd1_999_999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       key,
  output logic       busy,
  output logic       done,
  output logic [7:0] press_cnt
);

  localparam int unsigned SegW    = (GLITCH_MAX > 1) ? $clog2(GLITCH_MAX) : 1;
  localparam int unsigned LastSeg = (BOUNCE_CNT > 0) ? 2 * BOUNCE_CNT - 1 : 0;
  localparam int unsigned IdxW    = (LastSeg > 0) ? $clog2(LastSeg + 1) : 1;
  localparam logic [SegW-1:0] SegMax  = SegW'(GLITCH_MAX - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(LastSeg);

  typedef enum logic [2:0] {
    StIdle,
    StPressBounce,
    StHold,
    StReleaseBounce,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [SegW-1:0] seg_cnt_q, seg_cnt_d;
  logic [IdxW-1:0] seg_idx_q, seg_idx_d;
  logic [29:0]     hold_cnt_q, hold_cnt_d;
  logic            key_q, key_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [7:0]      press_cnt_q, press_cnt_d;
  // Down-counter preload for a new segment: width minus one.
  logic [SegW-1:0] seg_load;

`ifdef KEY_BOUNCE_LFSR_EN
  logic [15:0] lfsr_q, lfsr_nxt;
  logic        seg_start;

  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign seg_load = ({24'd0, lfsr_nxt[7:0]} > GLITCH_MAX - 1) ? SegMax : SegW'(lfsr_nxt[7:0]);
  assign seg_start = (state_d == StPressBounce || state_d == StReleaseBounce) &&
                     (state_d != state_q || seg_idx_d != seg_idx_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (seg_start) begin
      lfsr_q <= lfsr_nxt;
    end
  end
`else
  assign seg_load = SegMax;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      seg_cnt_q   <= '0;
      seg_idx_q   <= '0;
      hold_cnt_q  <= '0;
      key_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      seg_cnt_q   <= seg_cnt_d;
      seg_idx_q   <= seg_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      key_q       <= key_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    seg_cnt_d  = seg_cnt_q;
    seg_idx_d  = seg_idx_q;
    hold_cnt_d = hold_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (BOUNCE_CNT > 0) begin
            state_d   = StPressBounce;
            seg_idx_d = '0;
            seg_cnt_d = seg_load;
          end else begin
            state_d    = StHold;
            hold_cnt_d = HOLD_CYC - 30'd1;
          end
        end
      end
      StPressBounce, StReleaseBounce: begin
        if (seg_cnt_q != '0) begin
          seg_cnt_d = seg_cnt_q - SegW'(1);
        end else if (seg_idx_q != IdxLast) begin
          seg_idx_d = seg_idx_q + IdxW'(1);
          seg_cnt_d = seg_load;
        end else if (state_q == StPressBounce) begin
          state_d    = StHold;
          hold_cnt_d = HOLD_CYC - 30'd1;
        end else begin
          state_d = StDone;
        end
      end
      StHold: begin
        if (hold_cnt_q != 30'd0) begin
          hold_cnt_d = hold_cnt_q - 30'd1;
        end else if (BOUNCE_CNT > 0) begin
          state_d   = StReleaseBounce;
          seg_idx_d = '0;
          seg_cnt_d = seg_load;
        end else begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin
    key_d       = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    press_cnt_d = press_cnt_q;
    unique case (state_d)
      StPressBounce: begin
        key_d  = seg_idx_d[0];
        busy_d = 1'b1;
      end
      StHold: begin
        key_d  = 1'b0;
        busy_d = 1'b1;
      end
      StReleaseBounce: begin
        key_d  = ~seg_idx_d[0];
        busy_d = 1'b1;
      end
      StDone: begin
        busy_d      = 1'b1;
        done_d      = 1'b1;
        press_cnt_d = press_cnt_q + 8'd1;
      end
      default: ;
    endcase
  end

  assign key       = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = press_cnt_q;

endmodule
